// File: rtl/f2f_tx_pkg.sv
// Shared defaults and the dispatcher state encoding for the F2F TX lane dispatcher.
package f2f_tx_pkg;

    localparam int DEF_NUM_LANES = 5;
    localparam int DEF_LANE_W    = 8;
    localparam int DEF_BUSY_TO   = 15;
    localparam int DEF_FCNT_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } disp_state_e;

endpackage

// File: rtl/f2f_lane_ack_monitor.sv
// Watches the serializer busy lines of the lanes that were started.
// It reports whether every started lane is busy or every started lane is idle.
// It raises timeout once BUSY_TO enabled cycles pass without every started lane busy.
module f2f_lane_ack_monitor
    import f2f_tx_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int BUSY_TO   = DEF_BUSY_TO
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] mask,
    input  logic [NUM_LANES-1:0] lvds_busy_i,
    input  logic                 clear,
    input  logic                 enable,
    output logic                 all_busy,
    output logic                 all_idle,
    output logic                 timeout
);

    localparam int CNT_W = $clog2(BUSY_TO + 1);

    logic [NUM_LANES-1:0] masked_busy;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    // Busy lines on lanes outside the mask are ignored.
    always_comb begin
        masked_busy = lvds_busy_i & mask;
        all_busy    = (masked_busy == mask);
        all_idle    = (masked_busy == '0);
        // The counter reaches BUSY_TO on the edge where this is high.
        timeout     = enable & ~all_busy & (cnt_q == CNT_W'(BUSY_TO - 1));
    end

    // The wait counter advances only while waiting and not yet acknowledged.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !all_busy && cnt_q != CNT_W'(BUSY_TO)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/f2f_tx_lane_dispatcher.sv
// Feeds 40-bit beats to the 5-lane LVDS serializer bank.
// A beat launches only when every lane is idle. The dispatcher then waits for the
// started lanes to report busy and later idle, counting frames whose last beat drained.
//
// Handshake: a beat transfers on a rising edge where s_valid and s_ready are both high.
// s_valid may not depend on s_ready. s_ready is combinational: it is high only in IDLE
// with every serializer idle, and it is forced low while reset is asserted.
module f2f_tx_lane_dispatcher
    import f2f_tx_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int LANE_W    = DEF_LANE_W,
    parameter int BUSY_TO   = DEF_BUSY_TO,
    parameter int FCNT_W    = DEF_FCNT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LANES*LANE_W-1:0] s_data,
    input  logic [NUM_LANES-1:0]        s_keep,
    input  logic                        s_first,
    input  logic                        s_last,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [NUM_LANES*LANE_W-1:0] data_o,
    output logic [NUM_LANES-1:0]        start_o,
    output logic [NUM_LANES-1:0]        st_flag_o,
    output logic                        end_flag_o,
    input  logic [NUM_LANES-1:0]        lvds_busy_i,
    output logic [FCNT_W-1:0]           frame_cnt_o,
    output logic                        err_timeout_o,
    output logic                        idle_o
);

    disp_state_e                 state_q, state_d;
    logic [NUM_LANES*LANE_W-1:0] data_q, data_d;
    logic [NUM_LANES-1:0]        start_q, start_d;
    logic [NUM_LANES-1:0]        st_flag_q, st_flag_d;
    logic                        end_flag_q, end_flag_d;
    logic [NUM_LANES-1:0]        mask_q, mask_d;
    logic [FCNT_W-1:0]           frame_cnt_q, frame_cnt_d;
    logic                        err_timeout_q, err_timeout_d;

    logic accept;
    logic ack_clear;
    logic ack_enable;
    logic all_busy;
    logic all_idle;
    logic ack_timeout;

    f2f_lane_ack_monitor #(
        .NUM_LANES (NUM_LANES),
        .BUSY_TO   (BUSY_TO)
    ) u_ack_mon (
        .clk         (clk),
        .reset       (reset),
        .mask        (mask_q),
        .lvds_busy_i (lvds_busy_i),
        .clear       (ack_clear),
        .enable      (ack_enable),
        .all_busy    (all_busy),
        .all_idle    (all_idle),
        .timeout     (ack_timeout)
    );

    // Readiness and accept qualification.
    always_comb begin
        s_ready = (state_q == ST_IDLE) & ~(|lvds_busy_i) & ~reset;
        accept  = s_valid & s_ready;
    end

    // Next-state and output-register logic for the dispatch FSM.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        start_d       = '0;
        st_flag_d     = st_flag_q;
        end_flag_d    = end_flag_q;
        mask_d        = mask_q;
        frame_cnt_d   = frame_cnt_q;
        err_timeout_d = err_timeout_q;
        ack_clear     = 1'b0;
        ack_enable    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d     = s_data;
                    st_flag_d  = s_keep & {NUM_LANES{s_first}};
                    end_flag_d = s_last;
                    start_d    = s_keep;
                    mask_d     = s_keep;
                    if (s_keep != '0) begin
                        state_d = ST_LAUNCH;
                    end else if (s_last) begin
                        // An empty beat has nothing to shift, so its frame completes at once.
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    end
                end
            end
            ST_LAUNCH: begin
                ack_clear = 1'b1;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                ack_enable = 1'b1;
                if (all_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_timeout) begin
                    // The frame is abandoned without being counted.
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (all_idle) begin
                    state_d = ST_IDLE;
                    if (end_flag_q) begin
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset does not touch serializers already shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            data_q        <= '0;
            start_q       <= '0;
            st_flag_q     <= '0;
            end_flag_q    <= 1'b0;
            mask_q        <= '0;
            frame_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            start_q       <= start_d;
            st_flag_q     <= st_flag_d;
            end_flag_q    <= end_flag_d;
            mask_q        <= mask_d;
            frame_cnt_q   <= frame_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Output wiring.
    always_comb begin
        data_o        = data_q;
        start_o       = start_q;
        st_flag_o     = st_flag_q;
        end_flag_o    = end_flag_q;
        frame_cnt_o   = frame_cnt_q;
        err_timeout_o = err_timeout_q;
        idle_o        = (state_q == ST_IDLE);
    end

endmodule

// File: tb/tb_f2f_tx_lane_dispatcher.sv
// Bench for the F2F TX lane dispatcher.
// A behavioural serializer model drives busy. Directed and random beats are checked
// against expectations derived from the dispatch rules.
module tb_f2f_tx_lane_dispatcher;

    localparam int NL = 5;
    localparam int LW = 8;
    localparam int BT = 15;
    localparam int FW = 16;
    localparam int DW = NL * LW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] s_data;
    logic [NL-1:0] s_keep;
    logic          s_first, s_last, s_valid, s_ready;
    logic [DW-1:0] data_o;
    logic [NL-1:0] start_o, st_flag_o, lvds_busy_i;
    logic          end_flag_o;
    logic [FW-1:0] frame_cnt_o;
    logic          err_timeout_o, idle_o;

    f2f_tx_lane_dispatcher #(
        .NUM_LANES (NL),
        .LANE_W    (LW),
        .BUSY_TO   (BT),
        .FCNT_W    (FW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_keep        (s_keep),
        .s_first       (s_first),
        .s_last        (s_last),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .data_o        (data_o),
        .start_o       (start_o),
        .st_flag_o     (st_flag_o),
        .end_flag_o    (end_flag_o),
        .lvds_busy_i   (lvds_busy_i),
        .frame_cnt_o   (frame_cnt_o),
        .err_timeout_o (err_timeout_o),
        .idle_o        (idle_o)
    );

    // ---------------- serializer model ----------------
    // A started lane reports busy from the next edge for ser_len cycles.
    // suppress hides a lane's response; stuck holds a lane busy.
    int unsigned   ser_cnt [NL];
    int unsigned   ser_len;
    logic [NL-1:0] stuck;
    logic [NL-1:0] suppress;

    always @(posedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (start_o[k] && !suppress[k]) ser_cnt[k] <= ser_len;
            else if (ser_cnt[k] != 0)       ser_cnt[k] <= ser_cnt[k] - 1;
        end
    end

    always_comb begin
        lvds_busy_i = '0;
        for (int k = 0; k < NL; k++) lvds_busy_i[k] = stuck[k] | (ser_cnt[k] != 0);
    end

    // ---------------- scoreboard ----------------
    int            tests = 0;
    int            fails = 0;
    logic [FW-1:0] exp_frames;
    logic          exp_err;
    logic [NL-1:0] busy_at_edge;
    logic [NL-1:0] seen_start;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A start pulse may only follow an edge at which no lane was busy.
    always @(posedge clk) busy_at_edge <= lvds_busy_i;
    always @(negedge clk) begin
        seen_start = seen_start | start_o;
        if (|start_o) check("start_while_busy", 64'(busy_at_edge), 64'(0));
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge. Returns at the second negedge after the accept edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic [NL-1:0] k,
                             input logic f, input logic l, input logic hold);
        int n;
        s_data = d; s_keep = k; s_first = f; s_last = l; s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(n < 200), 64'(1));
        @(posedge clk);
        @(negedge clk);
        if (!hold) s_valid = 1'b0;
        check("data_o", 64'(data_o), 64'(d));
        check("st_flag_o", 64'(st_flag_o), 64'(k & {NL{f}}));
        check("end_flag_o", 64'(end_flag_o), 64'(l));
        check("start_o_pulse", 64'(start_o), 64'(k));
        if (k == '0) check("ready_after_empty", 64'(s_ready), 64'(1));
        @(negedge clk);
        check("start_o_drop", 64'(start_o), 64'(0));
    endtask

    // Waits for the dispatcher to reach IDLE, and optionally for all lanes to go quiet.
    task automatic drain(input logic need_free);
        int n;
        n = 0;
        while (!(idle_o && (!need_free || lvds_busy_i == '0)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_wait", 64'(n < 300), 64'(1));
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_frames"}, 64'(frame_cnt_o), 64'(exp_frames));
        check({tag, "_err"}, 64'(err_timeout_o), 64'(exp_err));
        check({tag, "_ready"}, 64'(s_ready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0]   r;
        logic [DW-1:0] d;
        logic [NL-1:0] k;
        logic          f, l;

        s_data = '0; s_keep = '0; s_first = 1'b0; s_last = 1'b0; s_valid = 1'b0;
        stuck = '0; suppress = '0; ser_len = 10; seen_start = '0;
        exp_frames = '0; exp_err = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(s_ready), 64'(0));
        check("rst_data", 64'(data_o), 64'(0));
        check("rst_start", 64'(start_o), 64'(0));
        check("rst_st_flag", 64'(st_flag_o), 64'(0));
        check("rst_end", 64'(end_flag_o), 64'(0));
        check("rst_frames", 64'(frame_cnt_o), 64'(0));
        check("rst_err", 64'(err_timeout_o), 64'(0));
        check("rst_idle", 64'(idle_o), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(s_ready), 64'(1));

        // Single full beat, one-beat frame
        send_beat(40'h05_0403_0201, 5'b11111, 1'b1, 1'b1, 1'b0);
        check("single_count_pending", 64'(frame_cnt_o), 64'(0));
        drain(1'b1);
        exp_frames = exp_frames + 1'b1;
        check_idle_state("single");

        // Three-beat frame with s_valid held high between beats
        send_beat(40'h11_2233_4455, 5'b11111, 1'b1, 1'b0, 1'b1);
        send_beat(40'h66_7788_99AA, 5'b11111, 1'b0, 1'b0, 1'b1);
        check("mid_frame_count", 64'(frame_cnt_o), 64'(exp_frames));
        send_beat(40'hBB_CCDD_EEFF, 5'b11111, 1'b0, 1'b1, 1'b0);
        check("last_beat_count_pending", 64'(frame_cnt_o), 64'(exp_frames));
        drain(1'b1);
        exp_frames = exp_frames + 1'b1;
        check_idle_state("three_beat");

        // Partial last beat; lane 4 stalls busy while the frame is in flight
        ser_len = 6;
        seen_start = '0;
        send_beat(40'hDE_ADBE_EF01, 5'b00111, 1'b1, 1'b1, 1'b0);
        stuck[4] = 1'b1;
        drain(1'b0);
        exp_frames = exp_frames + 1'b1;
        check("partial_frames", 64'(frame_cnt_o), 64'(exp_frames));
        check("partial_lanes34_quiet", 64'(seen_start[4:3]), 64'(0));
        check("stall_blocks_ready", 64'(s_ready), 64'(0));
        stuck[4] = 1'b0;
        @(negedge clk);
        check("stall_release_ready", 64'(s_ready), 64'(1));

        // Empty last beat completes the frame at once
        send_beat(40'h12_3456_789A, 5'b00000, 1'b1, 1'b1, 1'b0);
        exp_frames = exp_frames + 1'b1;
        check_idle_state("empty_beat");

        // Randomized beats against the frame-count model
        for (int i = 0; i < 24; i++) begin
            r = {$urandom(), $urandom()};
            d = r[DW-1:0];
            r = 64'($urandom());
            k = ($urandom_range(0, 2) == 0) ? r[NL-1:0] : 5'b11111;
            f = 1'($urandom_range(0, 1));
            l = 1'($urandom_range(0, 1));
            ser_len = $urandom_range(1, 12);
            send_beat(d, k, f, l, 1'b0);
            drain(1'b1);
            if (l) exp_frames = exp_frames + 1'b1;
            check_idle_state("random");
        end

        // Lane 2 never acknowledges: timeout
        ser_len = 8;
        suppress[2] = 1'b1;
        send_beat(40'hA5_A5A5_A5A5, 5'b11111, 1'b1, 1'b1, 1'b0);
        repeat (BT - 1) @(negedge clk);
        check("timeout_not_early", 64'(err_timeout_o), 64'(0));
        check("timeout_still_busy", 64'(idle_o), 64'(0));
        @(negedge clk);
        check("timeout_set", 64'(err_timeout_o), 64'(1));
        check("timeout_idle", 64'(idle_o), 64'(1));
        check("timeout_no_count", 64'(frame_cnt_o), 64'(exp_frames));
        exp_err = 1'b1;
        suppress[2] = 1'b0;
        drain(1'b1);
        for (int i = 0; i < 2; i++) begin
            send_beat(40'h01_0203_0405, 5'b11111, 1'b1, 1'b1, 1'b0);
            drain(1'b1);
            exp_frames = exp_frames + 1'b1;
            check_idle_state("sticky_err");
        end

        // Frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        exp_frames = 16'hFFFF;
        check("preload_frames", 64'(frame_cnt_o), 64'(exp_frames));
        send_beat(40'h00_0000_0000, 5'b00000, 1'b0, 1'b1, 1'b0);
        exp_frames = exp_frames + 1'b1;
        check("wrap_frames", 64'(frame_cnt_o), 64'(16'h0000));
        check_idle_state("wrap");

        // Reset while waiting for lanes to drain
        ser_len = 10;
        send_beat(40'h77_6655_4433, 5'b11111, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("pre_reset_busy", 64'(idle_o), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_data", 64'(data_o), 64'(0));
        check("mid_rst_start", 64'(start_o), 64'(0));
        check("mid_rst_st_flag", 64'(st_flag_o), 64'(0));
        check("mid_rst_end", 64'(end_flag_o), 64'(0));
        check("mid_rst_frames", 64'(frame_cnt_o), 64'(0));
        check("mid_rst_err", 64'(err_timeout_o), 64'(0));
        check("mid_rst_idle", 64'(idle_o), 64'(1));
        check("mid_rst_ready", 64'(s_ready), 64'(0));
        reset = 1'b0;
        exp_frames = '0;
        exp_err = 1'b0;
        @(negedge clk);
        check("post_rst_busy_blocks", 64'(s_ready), 64'(0));
        drain(1'b1);
        check_idle_state("post_rst_drain");
        send_beat(40'hC3_C3C3_C3C3, 5'b11111, 1'b1, 1'b1, 1'b0);
        drain(1'b1);
        exp_frames = exp_frames + 1'b1;
        check_idle_state("post_rst_frame");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
